md_unit: RTL
============

// Module: md_unit
// PURPOSE
//  Multiply/divide unit of the E stage: executes mult/multu/div/divu/mthi/mtlo and owns HI/LO.
//  Sits upstream of the memory stage. hi/lo feed the E-stage mfhi/mflo result mux that becomes
//  the M-stage mul_WD operand. busy drives the D-stage stall of every HI/LO-touching instruction.
// PARAMETERS
//  MUL_LAT   5   cycles from accepted multiply start to HI/LO update (>=1)
//  DIV_LAT   10  cycles from accepted divide start to HI/LO update (>=1)
// PORTS
//  clk      in   1   clock; all state updates on rising edge
//  reset    in   1   synchronous, active-low reset (0 = reset)
//  start    in   1   E-stage instruction issues md_op this cycle
//  md_op    in   4   0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MADD,8 MADDU,9 MSUB
//  rs_val   in   32  forwarded rs operand
//  rt_val   in   32  forwarded rt operand
//  busy     out  1   long op in flight
//  done     out  1   one-cycle pulse in the cycle HI/LO first show a long-op result
//  hi       out  32  HI register
//  lo       out  32  LO register
// BEHAVIOUR
//  - Reset (reset==0 at edge): hi=0, lo=0, busy=0, done=0, counter=0, pending result dropped.
//    Reset mid-operation aborts; HI/LO are not updated by the aborted op.
//  - Accept: start&&!busy&&op in {1..4,7..9}. At the edge ending cycle T: operands latched,
//    result computed into pend_hi/pend_lo, cnt<=LAT, busy<=1. busy is high in T+1..T+LAT.
//  - Each busy cycle cnt decrements; at the edge where cnt==1: hi/lo<=pend, busy<=0, done<=1.
//    New hi/lo visible from T+LAT+1; done is high only in T+LAT+1.
//  - start while busy: ignored (stall logic guarantees it never happens; unit must not corrupt state).
//  - start in the commit cycle (cnt==1): ignored. Back-to-back ops issue no earlier than T+LAT+1.
//  - MTHI/MTLO (start&&!busy): hi<=rs_val / lo<=rs_val at the edge ending T; busy stays 0; no done.
//  - MULT: {hi,lo}=$signed(rs)*$signed(rt), 64-bit. MULTU: unsigned 64-bit product.
//  - DIV: lo=signed quotient (truncate toward zero), hi=remainder (sign of dividend).
//    0x80000000/-1: lo=0x80000000, hi=0. DIVU: unsigned quotient/remainder.
//  - Divide by zero: op accepted, busy for DIV_LAT cycles, done pulses, HI/LO keep old values.
//  - NOP or undefined md_op: no state change.
//  - Outputs are registers; no combinational path from inputs to outputs.
// CONFIGURATION
//  MD_MADD_EN defined: ops 7..9 accepted with MUL_LAT latency:
//    MADD {hi,lo}+=signed product; MADDU += unsigned product; MSUB -= signed product;
//    64-bit wrap-around, accumulator base = hi/lo as of the accepting edge.
//  MD_MADD_EN undefined: ops 7..9 behave as NOP (not accepted, busy stays 0).
// STRUCTURE
//  Shared package/header md_defs: md_op encodings (MD_NOP..MD_MSUB), default latencies.
//  One sub-module, md_busy_ctr: loadable down-counter producing busy and the commit strobe.
//  Arithmetic, HI/LO and pending registers stay in md_unit.
// TESTING
//  1 MULT rs=0xFFFFFFFF rt=2 -> busy 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFFE, done 1 cycle.
//  2 MULTU rs=0xFFFFFFFF rt=2 -> hi=0x00000001 lo=0xFFFFFFFE after 5 cycles.
//  3 DIV rs=-7 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF after 10 cycles; DIVU 7/0 -> hi/lo unchanged.
//  4 MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, busy never 1.
//  5 MULT 3*4 then start DIV during busy -> DIV ignored; hi=0 lo=12; busy drops after 5 cycles.
//  6 Reset low in 3rd busy cycle of MULT 3*4 -> next cycle busy=0, hi=lo=0, done never pulses;
//    MD_MADD_EN builds: hi=0 lo=5, MADD 2*3 -> lo=11; without macro: op 7 is NOP, lo stays 5.

Source files
------------

// File: rtl/md_defs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_defs : md_op encodings and default latencies for the multiply/divide unit |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package md_defs;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9
  } md_op_e;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;

endpackage
`default_nettype wire

// File: rtl/md_busy_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_busy_ctr : loadable down-counter giving busy and the HI/LO commit strobe |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module md_busy_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             commit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy   = (cnt_q != '0);
  assign commit = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_unit : E-stage multiply/divide unit owning HI/LO                          |
// | Optional MD_MADD_EN enables MADD/MADDU/MSUB. Rev 1.0                         |
// +----------------------------------------------------------------------------+
module md_unit
  import md_defs::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic        done_q, done_d;

  logic             w_busy, w_commit, w_accept;
  logic             w_is_long, w_is_div, w_res_wr;
  logic [63:0]      w_res;
  logic [CNT_W-1:0] w_load_val;

  // Products: low 64 bits of the sign-extended multiply equal the signed product.
  logic [63:0] w_rs_sx, w_rt_sx, w_smul, w_umul;
  assign w_rs_sx = {{32{rs_val[31]}}, rs_val};
  assign w_rt_sx = {{32{rt_val[31]}}, rt_val};
  assign w_smul  = w_rs_sx * w_rt_sx;
  assign w_umul  = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  logic        w_rt_zero;
  logic [31:0] w_rs_mag, w_rt_mag, w_sden, w_mq, w_mr, w_sq, w_sr;
  logic [31:0] w_uden, w_uq, w_ur;
  assign w_rt_zero = (rt_val == 32'd0);
  assign w_rs_mag  = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign w_rt_mag  = rt_val[31] ? (32'd0 - rt_val) : rt_val;
  assign w_sden    = w_rt_zero ? 32'd1 : w_rt_mag;
  assign w_mq      = w_rs_mag / w_sden;
  assign w_mr      = w_rs_mag % w_sden;
  assign w_sq      = (rs_val[31] ^ rt_val[31]) ? (32'd0 - w_mq) : w_mq;
  assign w_sr      = rs_val[31] ? (32'd0 - w_mr) : w_mr;
  assign w_uden    = w_rt_zero ? 32'd1 : rt_val;
  assign w_uq      = rs_val / w_uden;
  assign w_ur      = rs_val % w_uden;

  always_comb begin
    w_is_long = 1'b0;
    w_is_div  = 1'b0;
    w_res     = 64'd0;
    w_res_wr  = 1'b1;
    case (md_op)
      MD_MULT:  begin w_is_long = 1'b1; w_res = w_smul; end
      MD_MULTU: begin w_is_long = 1'b1; w_res = w_umul; end
      MD_DIV: begin
        w_is_long = 1'b1;
        w_is_div  = 1'b1;
        w_res     = {w_sr, w_sq};
        w_res_wr  = !w_rt_zero;
      end
      MD_DIVU: begin
        w_is_long = 1'b1;
        w_is_div  = 1'b1;
        w_res     = {w_ur, w_uq};
        w_res_wr  = !w_rt_zero;
      end
`ifdef MD_MADD_EN
      MD_MADD:  begin w_is_long = 1'b1; w_res = {hi_q, lo_q} + w_smul; end
      MD_MADDU: begin w_is_long = 1'b1; w_res = {hi_q, lo_q} + w_umul; end
      MD_MSUB:  begin w_is_long = 1'b1; w_res = {hi_q, lo_q} - w_smul; end
`endif
      default: ;
    endcase
  end

  assign w_accept   = start && !w_busy && w_is_long;
  assign w_load_val = w_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  md_busy_ctr #(.CNT_W(CNT_W)) u_busy_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .load_val (w_load_val),
    .busy     (w_busy),
    .commit   (w_commit)
  );

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    done_d    = 1'b0;
    if (w_commit) begin
      done_d = 1'b1;
      if (pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (start && !w_busy) begin
      if (md_op == MD_MTHI) hi_d = rs_val;
      if (md_op == MD_MTLO) lo_d = rs_val;
      if (w_is_long) begin
        pend_hi_d = w_res[63:32];
        pend_lo_d = w_res[31:0];
        pend_wr_d = w_res_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      done_q    <= done_d;
    end
  end

  assign busy = w_busy;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire
